// File: rtl/rr_mux_arbiter_4_if.sv
// Handshake/data bundle between four requesters, the arbiter and the downstream consumer.
// master: requester/consumer side; slave: arbiter side.
interface rr_mux_arbiter_4_if #(
    parameter int unsigned WIDTH = 8
);
    logic [3:0]       req;
    logic [WIDTH-1:0] i0;
    logic [WIDTH-1:0] i1;
    logic [WIDTH-1:0] i2;
    logic [WIDTH-1:0] i3;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic [3:0]       gnt;
    logic             s0;
    logic             s1;
    logic [3:0]       ack;

    modport master (
        output req, i0, i1, i2, i3, out_ready,
        input  out_data, out_valid, gnt, s0, s1, ack
    );

    modport slave (
        input  req, i0, i1, i2, i3, out_ready,
        output out_data, out_valid, gnt, s0, s1, ack
    );
endinterface

// File: rtl/rr_mux_arbiter_4.sv
// 4-way arbiter + data mux with registered output and IDLE/BUSY handshake.
// Define ARB_ROUND_ROBIN_EN for round-robin; otherwise fixed priority (requester 0 highest).
module rr_mux_arbiter_4 #(
    parameter int unsigned WIDTH = 8
) (
    input logic              clk,
    input logic              rst,
    rr_mux_arbiter_4_if.slave bus
);
    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e           state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [3:0]       ack_q, ack_d;
    logic [1:0]       win_idx;
    logic [1:0]       idx;

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] ptr_q, ptr_d;

    // Scan downward so the lowest offset from the pointer is written last and wins.
    always_comb begin
        win_idx = '0;
        idx     = '0;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr_q + 2'(k);
            if (bus.req[idx]) win_idx = idx;
        end
    end
`else
    always_comb begin
        win_idx = '0;
        idx     = '0;
        for (int k = 3; k >= 0; k--) begin
            idx = 2'(k);
            if (bus.req[idx]) win_idx = idx;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        data_d  = data_q;
        ack_d   = '0;
`ifdef ARB_ROUND_ROBIN_EN
        ptr_d   = ptr_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (|bus.req) begin
                    state_d = StBusy;
                    gnt_d   = 4'b0001 << win_idx;
                    sel_d   = win_idx;
                    unique case (win_idx)
                        2'd0:    data_d = bus.i0;
                        2'd1:    data_d = bus.i1;
                        2'd2:    data_d = bus.i2;
                        default: data_d = bus.i3;
                    endcase
                end
            end
            StBusy: begin
                // Inputs are ignored while busy; only out_ready can end the transfer.
                if (bus.out_ready) begin
                    state_d = StIdle;
                    ack_d   = gnt_q;
                    gnt_d   = '0;
`ifdef ARB_ROUND_ROBIN_EN
                    ptr_d   = sel_q + 2'd1;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            sel_q   <= '0;
            data_q  <= '0;
            ack_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_valid = (state_q == StBusy);
    assign bus.gnt       = gnt_q;
    assign bus.s0        = sel_q[1];
    assign bus.s1        = sel_q[0];
    assign bus.ack       = ack_q;
endmodule
